count_bin2bcd_seq: RTL and testbench
====================================

// Module: count_bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift/add-3, one bit per clock).
//  Sits directly downstream of the 10..40 up/down counter: takes its 8-bit count_out and
//  produces packed BCD (hundreds/tens/ones) for the 2/3-digit display stage.
//  Start/done handshake; result register holds the last converted value.
// PARAMETERS
//  WIDTH   8   binary input width; conversion takes WIDTH shift cycles
//  DIGITS  3   BCD digits produced; must satisfy 10**DIGITS > 2**WIDTH-1
// PORTS
//  clk          in   1          rising-edge clock
//  reset_ah_in  in   1          synchronous reset, active-high
//  bin_in       in   WIDTH      binary value to convert (the upstream count)
//  start_in     in   1          request conversion; sampled only in IDLE
//  bcd_out      out  4*DIGITS   packed BCD, ones in [3:0], tens in [7:4], hundreds in [11:8]
//  busy_out     out  1          high while a conversion is in progress
//  done_out     out  1          one-cycle pulse when bcd_out updates
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: state=IDLE, bcd_out=0, busy_out=0,
//    done_out=0, shift/bit counters=0. Reset wins over every other input, incl. mid-conversion;
//    a conversion in progress is abandoned and bcd_out returns to 0.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE : start_in=1 -> capture bin_in into shift reg, clear BCD scratch, bit_cnt=WIDTH-1,
//           go SHIFT. busy_out=1 from the next cycle.
//    SHIFT: each cycle: every scratch digit >=5 gets +3, then {scratch,shift} <<= 1.
//           After the shift with bit_cnt==0 -> DONE; else bit_cnt--.
//    DONE : bcd_out <= scratch, done_out=1 for this one cycle, busy_out=0, -> IDLE.
//  - Latency: start sampled at edge N -> done_out high and bcd_out valid after edge N+WIDTH+1
//    (9 cycles for WIDTH=8). Next start accepted at the edge after done_out.
//  - start_in while busy (SHIFT/DONE) is ignored, not queued. bin_in changes after capture
//    have no effect on the conversion in flight.
//  - bcd_out changes only on the DONE cycle; holds between conversions.
//  - Add-3 check uses the pre-shift digit value; digits are 4-bit, no carry between digits
//    (the algorithm guarantees none). Top digit for WIDTH=8 never exceeds 2.
//  - Input 0 -> all-zero BCD; 2**WIDTH-1 (255) -> 0x255. No out-of-range flag.
// CONFIGURATION
//  - Macro BIN2BCD_AUTO_EN.
//    Defined: block keeps last_bin register (reset 0); in IDLE a conversion also starts
//    whenever bin_in != last_bin (start_in ORed in); last_bin updates on capture. Counter
//    output is tracked with no explicit start from the upstream controller.
//    Not defined: conversions start only on start_in; no last_bin register exists.
// STRUCTURE
//  - Shared package counter_pkg: state enum (ST_IDLE/ST_SHIFT/ST_DONE, 2-bit encoding),
//    BCD_DIGIT_W=4, ADD3_THRESH=5, COUNT_MIN=10, COUNT_MAX=40 (shared with the counter stage).
//  - One sub-module: bcd_digit_adj (combinational 4-bit: out = (in>=5) ? in+3 : in),
//    instantiated DIGITS times via generate.
//  - Top: FSM, bit counter, shift/scratch registers, output register.
// TESTING
//  1. reset_ah_in=1 two cycles -> bcd_out=0x000, busy_out=0, done_out=0.
//  2. bin_in=40, start_in pulse -> busy 8 cycles, done_out pulse 9th cycle, bcd_out=0x040;
//     repeat bin_in=10 -> 0x010, bin_in=255 -> 0x255, bin_in=0 -> 0x000.
//  3. start bin_in=39, pulse start_in again at cycle 3 with bin_in=17 -> only one done_out,
//     bcd_out=0x039.
//  4. start bin_in=25, assert reset_ah_in at cycle 4 -> bcd_out=0, busy_out=0, no done_out;
//     new start bin_in=12 completes with 0x012 in 9 cycles.
//  5. Sweep 0..255 back-to-back (start on the cycle after each done) -> every bcd_out matches
//     reference model; done_out spacing exactly 10 cycles.
//  6. BIN2BCD_AUTO_EN defined, start_in=0, bin_in steps 38,39,40,10 held 12 cycles each ->
//     bcd_out 0x038,0x039,0x040,0x010; bin_in held constant -> no further done_out.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the 10..40 counter stage and its BCD display converter:
// converter FSM encoding, BCD digit geometry and the counter range limits.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;
  localparam int COUNT_MIN   = 10;
  localparam int COUNT_MAX   = 40;

endpackage

// File: rtl/count_bin2bcd_seq_digit_adj.sv
// Single BCD digit correction for shift/add-3: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal place.
module bcd_digit_adj
  import counter_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= BCD_DIGIT_W'(ADD3_THRESH)) ? digit_i + BCD_DIGIT_W'(3)
                                                          : digit_i;

endmodule

// File: rtl/count_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift/add-3, one input bit per clock) with start/done handshake.
// Optional macro BIN2BCD_AUTO_EN: also start a conversion whenever bin_in differs from the last captured value.
module count_bin2bcd_seq
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_ah_in,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic [SCR_W-1:0]     scratch_adj;
  logic [SCR_W-1:0]     bcd_q, bcd_d;
  logic                 done_q, done_d;
  logic [SCR_W+WIDTH-1:0] shifted;
  logic                 go;

`ifdef BIN2BCD_AUTO_EN
  logic [WIDTH-1:0]     last_bin_q, last_bin_d;
  assign go = start_in | (bin_in != last_bin_q);
`else
  assign go = start_in;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits and the remaining binary bits move left together as one register.
  assign shifted = {scratch_adj, shift_q} << 1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
`ifdef BIN2BCD_AUTO_EN
    last_bin_d = last_bin_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH - 1);
          state_d   = ST_SHIFT;
`ifdef BIN2BCD_AUTO_EN
          last_bin_d = bin_in;
`endif
        end
      end
      ST_SHIFT: begin
        scratch_d = shifted[SCR_W+WIDTH-1:WIDTH];
        shift_d   = shifted[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
`ifdef BIN2BCD_AUTO_EN
      last_bin_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
`ifdef BIN2BCD_AUTO_EN
      last_bin_q <= last_bin_d;
`endif
    end
  end

  assign bcd_out  = bcd_q;
  assign busy_out = (state_q == ST_SHIFT);
  assign done_out = done_q;

endmodule

// File: tb/tb_count_bin2bcd_seq.sv
// Directed self-checking bench for count_bin2bcd_seq (WIDTH=8, DIGITS=3).
module tb_count_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset_ah_in;
  logic [7:0]  bin_in;
  logic        start_in;
  logic [11:0] bcd_out;
  logic        busy_out;
  logic        done_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_done_cyc;
  int lat, nbusy, ndone;
  logic [11:0] held_bcd;

  count_bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk         (clk),
    .reset_ah_in (reset_ah_in),
    .bin_in      (bin_in),
    .start_in    (start_in),
    .bcd_out     (bcd_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // Pulse start with value b; returns edges from the start edge until done_out, and busy cycles seen.
  task automatic run_conv(input logic [7:0] b, output int l, output int nb);
    bin_in   = b;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    l  = 0;
    nb = 0;
    while (!done_out && l < 30) begin
      if (busy_out) nb++;
      step();
      l++;
    end
    if (done_out) last_done_cyc = cyc;
  endtask

  initial begin
    reset_ah_in = 1'b1;
    bin_in      = 8'd0;
    start_in    = 1'b0;
    last_done_cyc = 0;
    step();
    step();
    chk("reset_bcd",  32'(bcd_out),  32'h000);
    chk("reset_busy", 32'(busy_out), 32'd0);
    chk("reset_done", 32'(done_out), 32'd0);
    reset_ah_in = 1'b0;
    step();

    run_conv(8'd40, lat, nbusy);
    chk("c40_lat",  32'(lat),   32'd9);
    chk("c40_busy", 32'(nbusy), 32'd8);
    chk("c40_bcd",  32'(bcd_out), 32'h040);
    run_conv(8'd10, lat, nbusy);
    chk("c10_lat", 32'(lat), 32'd9);
    chk("c10_bcd", 32'(bcd_out), 32'h010);
    run_conv(8'd255, lat, nbusy);
    chk("c255_lat", 32'(lat), 32'd9);
    chk("c255_bcd", 32'(bcd_out), 32'h255);
    run_conv(8'd0, lat, nbusy);
    chk("c0_lat", 32'(lat), 32'd9);
    chk("c0_bcd", 32'(bcd_out), 32'h000);
    chk("c0_busy_after", 32'(busy_out), 32'd0);

    // Second start while shifting must be ignored.
    bin_in   = 8'd39;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    step();
    step();
    bin_in   = 8'd17;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    ndone    = 0;
    held_bcd = 12'h000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_out) begin
        ndone++;
        held_bcd = bcd_out;
      end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_bcd",   32'(held_bcd), 32'h039);
    chk("hold_bcd", 32'(bcd_out), 32'h039);

    // Reset in the middle of a conversion abandons it.
    bin_in   = 8'd25;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    step();
    step();
    step();
    reset_ah_in = 1'b1;
    step();
    reset_ah_in = 1'b0;
    chk("midrst_bcd",  32'(bcd_out),  32'h000);
    chk("midrst_busy", 32'(busy_out), 32'd0);
    chk("midrst_done", 32'(done_out), 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_out) ndone++;
    end
    chk("midrst_nodone", 32'(ndone), 32'd0);
    run_conv(8'd12, lat, nbusy);
    chk("c12_lat", 32'(lat), 32'd9);
    chk("c12_bcd", 32'(bcd_out), 32'h012);

    // Back-to-back sweep of every input value.
    for (int v = 0; v < 256; v++) begin
      int prev_done;
      prev_done = last_done_cyc;
      run_conv(8'(v), lat, nbusy);
      chk($sformatf("sweep_bcd_%0d", v), 32'(bcd_out), 32'(ref_bcd(v)));
      if (v > 0) chk($sformatf("sweep_gap_%0d", v), 32'(last_done_cyc - prev_done), 32'd10);
    end

`ifdef BIN2BCD_AUTO_EN
    reset_ah_in = 1'b1;
    bin_in      = 8'd0;
    start_in    = 1'b0;
    step();
    reset_ah_in = 1'b0;
    begin
      logic [7:0]  av [4];
      logic [11:0] ae [4];
      av = '{8'd38, 8'd39, 8'd40, 8'd10};
      ae = '{12'h038, 12'h039, 12'h040, 12'h010};
      for (int k = 0; k < 4; k++) begin
        bin_in = av[k];
        ndone  = 0;
        for (int i = 0; i < 12; i++) begin
          step();
          if (done_out) ndone++;
        end
        chk($sformatf("auto_ndone_%0d", k), 32'(ndone), 32'd1);
        chk($sformatf("auto_bcd_%0d", k), 32'(bcd_out), 32'(ae[k]));
      end
      ndone = 0;
      for (int i = 0; i < 24; i++) begin
        step();
        if (done_out) ndone++;
      end
      chk("auto_hold_nodone", 32'(ndone), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
